// File: rtl/sbox_pkg.sv
// Shared constants and FSM encoding for the S-box sharing controller.
// Byte counts per job type and owner encoding used by the arbiter and datapath.
package sbox_pkg;

    localparam int ST_BYTES = 16;
    localparam int KS_BYTES = 4;

    localparam logic OWNER_ST = 1'b0;
    localparam logic OWNER_KS = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sbox_share_ctrl_arb.sv
// Two-way arbiter between state path and key schedule, grant is combinational.
// Tie pointer only advances when a tie is actually accepted; KS_PRIO pins ties to key.
module rr_arb2 #(
    parameter bit KS_PRIO = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic req_st,
    input  logic req_ks,
    input  logic accept,
    output logic gnt_st,
    output logic gnt_ks
);

    logic ks_first_q, ks_first_d;

    always_comb begin
        gnt_st     = 1'b0;
        gnt_ks     = 1'b0;
        ks_first_d = ks_first_q;
        if (req_st && req_ks) begin
            if (KS_PRIO || ks_first_q) begin
                gnt_ks = 1'b1;
            end else begin
                gnt_st = 1'b1;
            end
            // The tie winner drops to lowest priority for the next tie.
            if (accept && !KS_PRIO) begin
                ks_first_d = ~ks_first_q;
            end
        end else begin
            gnt_st = req_st;
            gnt_ks = req_ks;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ks_first_q <= 1'b0;
        end else begin
            ks_first_q <= ks_first_d;
        end
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares one byte-serial S-box port between SubBytes (16 B) and SubWord (4 B) jobs.
// Done arrives N+SB_LAT+1 cycles after ack; a held request waits for the next IDLE.
module sbox_share_ctrl
    import sbox_pkg::*;
#(
    parameter int SB_LAT  = 1,
    parameter bit KS_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         ks_req,
    input  logic [31:0]  ks_in,
    output logic         ks_ack,
    output logic         ks_done,
    output logic [31:0]  ks_out,
    output logic         sb_rd,
    output logic [7:0]   sb_addr,
    input  logic [7:0]   sb_data,
    output logic         busy,
    output logic         owner
);

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic [127:0]   job_q, job_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     wait_q, wait_d;
    logic [127:0]   res_q, res_d;
    logic [127:0]   st_out_q, st_out_d;
    logic [31:0]    ks_out_q, ks_out_d;

    logic [SB_LAT-1:0] tag_vld_q;
    logic [3:0]        tag_idx_q [SB_LAT];

    logic gnt_st, gnt_ks;
    logic idle, ack_any;
    logic rd_int;
    logic [3:0] last_byte;
    logic land_vld;
    logic [3:0] land_idx;

    assign idle    = (state_q == S_IDLE);
    assign ack_any = idle && !rst && (gnt_st || gnt_ks);

    rr_arb2 #(
        .KS_PRIO (KS_PRIO)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_st (st_req),
        .req_ks (ks_req),
        .accept (ack_any),
        .gnt_st (gnt_st),
        .gnt_ks (gnt_ks)
    );

    assign last_byte = (owner_q == OWNER_KS) ? 4'(KS_BYTES - 1) : 4'(ST_BYTES - 1);
    assign land_vld  = tag_vld_q[SB_LAT-1];
    assign land_idx  = tag_idx_q[SB_LAT-1];

    // Returning bytes land by their tag, so result assembly is independent of SB_LAT.
    always_comb begin
        res_d = res_q;
        if (land_vld) begin
            res_d[{land_idx, 3'b000} +: 8] = sb_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        job_d    = job_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        st_out_d = st_out_q;
        ks_out_d = ks_out_q;
        rd_int   = 1'b0;
        sb_addr  = 8'h00;
        st_done  = 1'b0;
        ks_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ack_any) begin
                    owner_d = gnt_ks ? OWNER_KS : OWNER_ST;
                    job_d   = gnt_ks ? {96'h0, ks_in} : st_in;
                    cnt_d   = 4'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rd_int  = 1'b1;
                sb_addr = job_q[{cnt_q, 3'b000} +: 8];
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == last_byte) begin
                    wait_d  = 2'd0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                wait_d = wait_q + 2'd1;
                // Last byte lands on this edge; publish the merged result directly.
                if (wait_q == 2'(SB_LAT - 1)) begin
                    state_d = S_DONE;
                    if (owner_q == OWNER_KS) begin
                        ks_out_d = res_d[31:0];
                    end else begin
                        st_out_d = res_d;
                    end
                end
            end
            S_DONE: begin
                st_done = (owner_q == OWNER_ST);
                ks_done = (owner_q == OWNER_KS);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            rd_int  = 1'b0;
            sb_addr = 8'h00;
            st_done = 1'b0;
            ks_done = 1'b0;
        end
    end

    assign sb_rd  = rd_int;
    assign st_ack = ack_any && gnt_st;
    assign ks_ack = ack_any && gnt_ks;
    assign busy   = !rst && (!idle || ack_any);
    assign owner  = busy ? (idle ? gnt_ks : owner_q) : 1'b0;
    assign st_out = st_out_q;
    assign ks_out = ks_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWNER_ST;
            job_q     <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            res_q     <= '0;
            st_out_q  <= '0;
            ks_out_q  <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < SB_LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            job_q        <= job_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            res_q        <= res_d;
            st_out_q     <= st_out_d;
            ks_out_q     <= ks_out_d;
            tag_vld_q[0] <= rd_int;
            tag_idx_q[0] <= cnt_q;
            for (int i = 1; i < SB_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

endmodule
